l3_slave_router: RTL and testbench
==================================

# l3_slave_router

Parametrised, transaction-locked router between the L3 command interface and N_SLV crypto engine slaves (MK, SSK, ECC, HASH, ARIA, and future engines). It latches the slave index at the start of each transaction and holds it until the slave responds. It issues a one-cycle error response for invalid selects and for slaves that stall past a timeout. It replaces the unregistered per-engine select/mux bridge and sits between the L3 framer and the engine array.

## Interface
- N_SLV, 5: number of slaves; legal l3_sel values are 1..N_SLV.
- SW, 4: l3_sel width; must satisfy 2^SW > N_SLV.
- DW, 32: read-data width.
- RW, 8: response-code width.
- TIMEOUT, 255: idle cycles allowed in ACTIVE before a timeout error; 0 disables the timeout.
- ERR_SEL, 8'hFF: response code for an invalid select.
- ERR_TO, 8'hFE: response code for a timeout.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- l3_req  in  1  one-cycle transaction-start strobe
- l3_sel  in  SW  slave number, sampled only with l3_req in IDLE
- l3_rd  out  DW  read data from the locked slave
- l3_rd_vld  out  1  read-data valid
- l3_wd_rdy  out  1  write-data ready
- resp  out  RW  response code
- resp_vld  out  1  response valid
- busy  out  1  high whenever the state is not IDLE
- err_pulse  out  1  one-cycle pulse on any error response
- slv_sel  out  N_SLV  one-hot slave select; bit k selects slave number k+1
- slv_rd  in  N_SLV*DW  packed read data; slave k occupies [k*DW +: DW]
- slv_rd_vld  in  N_SLV  per-slave read valid
- slv_wd_rdy  in  N_SLV  per-slave write ready
- slv_resp  in  N_SLV*RW  packed response codes
- slv_resp_vld  in  N_SLV  per-slave response valid

## Operation
- States: IDLE, ACTIVE, ERR.
- IDLE + l3_req + (1 ≤ l3_sel ≤ N_SLV):
  - latch idx = l3_sel−1;
  - clear the timer;
  - go to ACTIVE.
- IDLE + l3_req + (l3_sel = 0 or l3_sel > N_SLV): latch code ERR_SEL, go to ERR.
- ACTIVE:
  - slv_sel = one-hot(idx).
  - l3_rd, l3_rd_vld, l3_wd_rdy, resp and resp_vld combinationally follow slave idx.
  - Activity = slv_rd_vld[idx] | slv_wd_rdy[idx] | slv_resp_vld[idx].
  - slv_resp_vld[idx] → next state IDLE.
  - Otherwise, activity clears the timer.
  - No activity: if timer = TIMEOUT−1 (and TIMEOUT≠0), latch code ERR_TO and go to ERR; else timer+1.
- ERR: resp = latched code, resp_vld = 1, err_pulse = 1, slv_sel = 0; next state IDLE unconditionally.
- Outside ACTIVE and ERR, every data/valid output is 0, resp is 0, and slv_sel is 0.
- Signals from non-selected slaves are ignored in all states, including stray resp_vld.
- l3_req and l3_sel are ignored in ACTIVE and ERR; no queuing.
- Timer width is $clog2(TIMEOUT+1). The timer saturates and never wraps.

## Timing
- Reset: state IDLE, timer 0, idx 0, latched code 0. All outputs 0, including busy, err_pulse and slv_sel.
- Valid l3_req in cycle n: slv_sel and busy asserted in n+1.
- Invalid l3_req in cycle n: resp_vld/err_pulse high in n+1 only; busy high in n+1 only; IDLE in n+2.
- Slave completion: slave resp_vld in cycle m appears on resp_vld in m (zero latency). slv_sel and busy are low in m+1.
- l3_req in cycle m (the completion cycle) is ignored. The earliest accepted next request is in m+1.
- Timeout with no activity from entry cycle n+1: ACTIVE spans n+1..n+TIMEOUT; ERR with resp = ERR_TO is at n+TIMEOUT+1.
- Precedence in the threshold cycle: slave resp_vld beats timeout; any activity beats timeout.
- rst asserted mid-ACTIVE or in ERR: next cycle is IDLE with all outputs 0. No error response is emitted.

## Test plan
- Reset with all inputs X-free → every output 0 and busy 0 for the whole reset period and the first cycle after it.
- l3_sel=3 with l3_req; slave 2 drives rd=32'hA5A5_0001 with rd_vld, then resp=8'h00 with resp_vld → slv_sel=5'b00100 one cycle later; l3_rd=32'hA5A5_0001; resp=8'h00 in the same cycle as the slave; busy low the next cycle.
- l3_sel=0, and l3_sel=7 (N_SLV=5) → one-cycle resp=8'hFF, resp_vld=1, err_pulse=1; slv_sel stays 0.
- TIMEOUT=4; l3_sel=1 and the slave stays silent → resp=8'hFE exactly 5 cycles after l3_req; then IDLE.
- TIMEOUT=4; slave wd_rdy pulses every 3 cycles for 20 cycles, then resp_vld → no timeout; normal completion.
- During ACTIVE on slave 1: change l3_sel to 4, pulse l3_req, and drive slv_resp_vld[3] → all ignored; slv_sel stays 5'b00001. Also assert rst mid-transaction → IDLE next cycle with no resp_vld.

Source files
------------

// File: rtl/l3_slave_router.sv
// Transaction-locked router between the L3 command interface and N_SLV crypto engines.
// Latches the slave index per transaction and returns a one-cycle error for bad selects or stalls.
module l3_slave_router #(
  parameter int             N_SLV   = 5,
  parameter int             SW      = 4,
  parameter int             DW      = 32,
  parameter int             RW      = 8,
  parameter int             TIMEOUT = 255,
  parameter logic [RW-1:0]  ERR_SEL = 8'hFF,
  parameter logic [RW-1:0]  ERR_TO  = 8'hFE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                l3_req,
  input  logic [SW-1:0]       l3_sel,
  output logic [DW-1:0]       l3_rd,
  output logic                l3_rd_vld,
  output logic                l3_wd_rdy,
  output logic [RW-1:0]       resp,
  output logic                resp_vld,
  output logic                busy,
  output logic                err_pulse,
  output logic [N_SLV-1:0]    slv_sel,
  input  logic [N_SLV*DW-1:0] slv_rd,
  input  logic [N_SLV-1:0]    slv_rd_vld,
  input  logic [N_SLV-1:0]    slv_wd_rdy,
  input  logic [N_SLV*RW-1:0] slv_resp,
  input  logic [N_SLV-1:0]    slv_resp_vld
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_ERR    = 2'd2;

  localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [SW-1:0] SEL_MAX = SW'(N_SLV);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic [RW-1:0] code;

  logic sel_ok;
  logic act;

  assign sel_ok = (l3_sel != '0) && (l3_sel <= SEL_MAX);
  assign act    = slv_rd_vld[idx] | slv_wd_rdy[idx] | slv_resp_vld[idx];

  // NOTE: sequential state uses <= so every register samples pre-edge values; = here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      timer <= '0;
      code  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (l3_req) begin
            if (sel_ok) begin
              idx   <= IW'(l3_sel - SW'(1));
              timer <= '0;
              state <= S_ACTIVE;
            end else begin
              code  <= ERR_SEL;
              state <= S_ERR;
            end
          end
        end
        S_ACTIVE: begin
          // Completion beats activity, and activity beats the timeout threshold.
          if (slv_resp_vld[idx]) begin
            state <= S_IDLE;
          end else if (act) begin
            timer <= '0;
          end else if ((TIMEOUT != 0) && (timer == TO_LAST)) begin
            code  <= ERR_TO;
            state <= S_ERR;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    l3_rd     = '0;
    l3_rd_vld = 1'b0;
    l3_wd_rdy = 1'b0;
    resp      = '0;
    resp_vld  = 1'b0;
    err_pulse = 1'b0;
    slv_sel   = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_ACTIVE: begin
        slv_sel   = N_SLV'(1) << idx;
        l3_rd     = slv_rd[idx*DW +: DW];
        l3_rd_vld = slv_rd_vld[idx];
        l3_wd_rdy = slv_wd_rdy[idx];
        resp      = slv_resp[idx*RW +: RW];
        resp_vld  = slv_resp_vld[idx];
      end
      S_ERR: begin
        resp      = code;
        resp_vld  = 1'b1;
        err_pulse = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l3_slave_router.sv
// Directed bench for l3_slave_router with TIMEOUT=4; inputs change just after posedge,
// outputs are checked at the following negedge.
module tb_l3_slave_router;

  localparam int N  = 5;
  localparam int SW = 4;
  localparam int DW = 32;
  localparam int RW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            l3_req;
  logic [SW-1:0]   l3_sel;
  logic [DW-1:0]   l3_rd;
  logic            l3_rd_vld;
  logic            l3_wd_rdy;
  logic [RW-1:0]   resp;
  logic            resp_vld;
  logic            busy;
  logic            err_pulse;
  logic [N-1:0]    slv_sel;
  logic [N*DW-1:0] slv_rd;
  logic [N-1:0]    slv_rd_vld;
  logic [N-1:0]    slv_wd_rdy;
  logic [N*RW-1:0] slv_resp;
  logic [N-1:0]    slv_resp_vld;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l3_slave_router #(
    .N_SLV(N), .SW(SW), .DW(DW), .RW(RW), .TIMEOUT(4),
    .ERR_SEL(8'hFF), .ERR_TO(8'hFE)
  ) dut (
    .clk(clk), .rst(rst), .l3_req(l3_req), .l3_sel(l3_sel),
    .l3_rd(l3_rd), .l3_rd_vld(l3_rd_vld), .l3_wd_rdy(l3_wd_rdy),
    .resp(resp), .resp_vld(resp_vld), .busy(busy), .err_pulse(err_pulse),
    .slv_sel(slv_sel), .slv_rd(slv_rd), .slv_rd_vld(slv_rd_vld),
    .slv_wd_rdy(slv_wd_rdy), .slv_resp(slv_resp), .slv_resp_vld(slv_resp_vld)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    l3_req       = 1'b0;
    l3_sel       = '0;
    slv_rd       = '0;
    slv_rd_vld   = '0;
    slv_wd_rdy   = '0;
    slv_resp     = '0;
    slv_resp_vld = '0;
  endtask

  // Idle check: every output quiet.
  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".out"}, {l3_rd, l3_rd_vld, l3_wd_rdy, resp, resp_vld, err_pulse, slv_sel}, '0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset period and first cycle after it.
    for (int i = 0; i < 3; i++) begin
      sample();
      check_quiet("reset");
      tick();
    end
    rst = 1'b0;
    sample();
    check_quiet("post_reset");

    // Normal transaction on slave number 3.
    tick();
    l3_req = 1'b1; l3_sel = 4'd3;
    sample();
    check("req_cycle_busy", busy, 1'b0);
    tick();
    clear_inputs();
    slv_rd[1*DW +: DW] = 32'hA5A5_0001; slv_rd_vld[1] = 1'b1;
    slv_rd[2*DW +: DW] = 32'hDEAD_BEEF; slv_rd_vld[2] = 1'b1;
    sample();
    check("s3_slv_sel", slv_sel, 5'b00100);
    check("s3_busy", busy, 1'b1);
    check("s3_rd", l3_rd, 32'hDEAD_BEEF);
    check("s3_rd_vld", l3_rd_vld, 1'b1);
    tick();
    clear_inputs();
    slv_rd[2*DW +: DW] = 32'hA5A5_0001; slv_rd_vld[2] = 1'b1;
    slv_rd_vld[1] = 1'b1;
    sample();
    check("s3_rd2", l3_rd, 32'hA5A5_0001);
    tick();
    clear_inputs();
    slv_resp[2*RW +: RW] = 8'h00; slv_resp_vld[2] = 1'b1;
    slv_resp[1*RW +: RW] = 8'h5A;
    sample();
    check("s3_resp_vld", resp_vld, 1'b1);
    check("s3_resp", resp, 8'h00);
    check("s3_err_pulse", err_pulse, 1'b0);

    // Invalid select 0 issued the cycle after completion.
    tick();
    clear_inputs();
    l3_req = 1'b1; l3_sel = 4'd0;
    sample();
    check("s3_done_busy", busy, 1'b0);
    check("s3_done_sel", slv_sel, 5'b00000);
    tick();
    clear_inputs();
    sample();
    check("sel0_resp", resp, 8'hFF);
    check("sel0_vld", {resp_vld, err_pulse, busy}, 3'b111);
    check("sel0_slv_sel", slv_sel, 5'b00000);
    tick();
    sample();
    check_quiet("sel0_after");

    // Invalid select 7.
    l3_req = 1'b1; l3_sel = 4'd7;
    tick();
    clear_inputs();
    sample();
    check("sel7_resp", resp, 8'hFF);
    check("sel7_vld", {resp_vld, err_pulse, busy}, 3'b111);
    check("sel7_slv_sel", slv_sel, 5'b00000);
    tick();
    sample();
    check_quiet("sel7_after");

    // Timeout: slave 1 silent; ACTIVE for 4 cycles, ERR_TO at req+5.
    l3_req = 1'b1; l3_sel = 4'd1;
    tick();
    clear_inputs();
    for (int i = 1; i <= 4; i++) begin
      sample();
      check("to_active_sel", slv_sel, 5'b00001);
      check("to_active_vld", resp_vld, 1'b0);
      tick();
    end
    sample();
    check("to_resp", resp, 8'hFE);
    check("to_vld", {resp_vld, err_pulse, slv_sel}, {2'b11, 5'b00000});
    tick();
    sample();
    check_quiet("to_after");

    // Periodic wd_rdy keeps the timer from expiring; completion cycle also carries a stray req.
    l3_req = 1'b1; l3_sel = 4'd1;
    tick();
    clear_inputs();
    for (int i = 0; i < 20; i++) begin
      slv_wd_rdy[0] = (i % 3 == 2);
      sample();
      check("wd_busy", {busy, resp_vld, err_pulse}, 3'b100);
      check("wd_rdy", l3_wd_rdy, (i % 3 == 2));
      tick();
    end
    clear_inputs();
    slv_resp[0 +: RW] = 8'h3C; slv_resp_vld[0] = 1'b1;
    l3_req = 1'b1; l3_sel = 4'd2;
    sample();
    check("wd_resp", {resp_vld, resp}, {1'b1, 8'h3C});
    tick();
    clear_inputs();
    sample();
    check_quiet("wd_req_ignored");

    // Threshold precedence: completion on the 4th silent ACTIVE cycle wins over timeout.
    l3_req = 1'b1; l3_sel = 4'd5;
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) tick();
    slv_resp[4*RW +: RW] = 8'h11; slv_resp_vld[4] = 1'b1;
    sample();
    check("thr_resp", {resp_vld, err_pulse, resp}, {2'b10, 8'h11});
    tick();
    clear_inputs();
    sample();
    check_quiet("thr_after");

    // Ignored inputs during ACTIVE, then reset mid-transaction.
    l3_req = 1'b1; l3_sel = 4'd1;
    tick();
    clear_inputs();
    l3_req = 1'b1; l3_sel = 4'd4;
    slv_resp[3*RW +: RW] = 8'h77; slv_resp_vld[3] = 1'b1;
    sample();
    check("ign_sel", slv_sel, 5'b00001);
    check("ign_resp", {resp_vld, resp}, '0);
    tick();
    sample();
    check("ign_sel2", {busy, slv_sel}, {1'b1, 5'b00001});
    rst = 1'b1;
    tick();
    clear_inputs();
    rst = 1'b0;
    sample();
    check_quiet("rst_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
